mult_arb: RTL and testbench

MULT_ARB -- requirements
Module: mult_arb

---
 rtl/mult_arb_if.sv | 30 +++
 rtl/mult_arb.sv | 146 ++++++++++++++
 tb/tb_mult_arb.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_arb_if.sv
// Request, multiplier and response bundle between requesters and mult_arb.
interface mult_arb_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [NUM_REQ*WIDTH-1:0] req_a_i;
    logic [NUM_REQ*WIDTH-1:0] req_b_i;
    logic                     mult_start_o;
    logic [WIDTH-1:0]         mult_a_o;
    logic [WIDTH-1:0]         mult_b_o;
    logic [WIDTH-1:0]         mult_product_i;
    logic                     mult_done_i;
    logic [NUM_REQ-1:0]       resp_valid_o;
    logic [WIDTH-1:0]         resp_product_o;
    logic                     err_o;

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, mult_product_i, mult_done_i,
        output req_ready_o, mult_start_o, mult_a_o, mult_b_o,
               resp_valid_o, resp_product_o, err_o
    );

    modport master (
        output req_valid_i, req_a_i, req_b_i, mult_product_i, mult_done_i,
        input  req_ready_o, mult_start_o, mult_a_o, mult_b_o,
               resp_valid_o, resp_product_o, err_o
    );
endinterface

// File: rtl/mult_arb.sv
// Round-robin arbiter sharing one fixed-latency pipelined multiplier, with a tag
// pipeline routing each product back to its requester. Perf counters: MULT_ARB_PERF_EN.
module mult_arb #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned STAGES  = 16,
    parameter int unsigned NUM_REQ = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    mult_arb_if.slave   bus
`ifdef MULT_ARB_PERF_EN
    ,
    output logic [31:0] perf_issue_o,
    output logic [31:0] perf_stall_o
`endif
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned BIT_W = $clog2(NUM_REQ * WIDTH);

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } tag_t;

    logic [IDX_W-1:0]   ptr_q;
    logic [NUM_REQ-1:0] gnt_c;
    logic [IDX_W-1:0]   gnt_idx_c;
    logic [IDX_W-1:0]   ptr_nxt_c;
    logic [WIDTH-1:0]   sel_a_c;
    logic [WIDTH-1:0]   sel_b_c;
    logic               found_c;
    logic               xfer_c;
    int unsigned        cand_c;

    logic               start_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [IDX_W-1:0]   issue_idx_q;
    tag_t               tags_q [STAGES];
    tag_t               tag_out;
    logic [NUM_REQ-1:0] resp_valid_q;
    logic [WIDTH-1:0]   resp_product_q;
    logic               err_q;

    // First valid requester at or after ptr wins; operands muxed alongside.
    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        ptr_nxt_c = ptr_q;
        sel_a_c   = '0;
        sel_b_c   = '0;
        found_c   = 1'b0;
        cand_c    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_c = (32'(ptr_q) + i) % NUM_REQ;
            if (!found_c && bus.req_valid_i[IDX_W'(cand_c)]) begin
                found_c                = 1'b1;
                gnt_c[IDX_W'(cand_c)]  = 1'b1;
                gnt_idx_c              = IDX_W'(cand_c);
                ptr_nxt_c              = (cand_c == NUM_REQ - 1) ? '0 : IDX_W'(cand_c + 1);
                sel_a_c                = bus.req_a_i[BIT_W'(cand_c * WIDTH) +: WIDTH];
                sel_b_c                = bus.req_b_i[BIT_W'(cand_c * WIDTH) +: WIDTH];
            end
        end
    end

    assign bus.req_ready_o = rst_ni ? gnt_c : '0;
    assign xfer_c          = |(bus.req_valid_i & bus.req_ready_o);

    // Issue stage: pointer advance and operand capture on each transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            start_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            issue_idx_q <= '0;
        end else begin
            start_q <= xfer_c;
            if (xfer_c) begin
                ptr_q       <= ptr_nxt_c;
                a_q         <= sel_a_c;
                b_q         <= sel_b_c;
                issue_idx_q <= gnt_idx_c;
            end
        end
    end

    // Tag pipeline entry [0] is loaded alongside the start pulse, so its output
    // lines up with mult_done_i STAGES cycles later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < STAGES; i++) tags_q[i] <= '0;
        end else begin
            tags_q[0] <= '{vld: start_q, idx: issue_idx_q};
            for (int unsigned i = 1; i < STAGES; i++) tags_q[i] <= tags_q[i-1];
        end
    end

    assign tag_out = tags_q[STAGES-1];

    // Response capture and sticky tag/done mismatch detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_q   <= '0;
            resp_product_q <= '0;
            err_q          <= 1'b0;
        end else begin
            resp_valid_q <= '0;
            if (tag_out.vld && bus.mult_done_i) begin
                resp_product_q <= bus.mult_product_i;
                resp_valid_q   <= NUM_REQ'(1) << tag_out.idx;
            end
            if (tag_out.vld != bus.mult_done_i) err_q <= 1'b1;
        end
    end

    assign bus.mult_start_o   = start_q;
    assign bus.mult_a_o       = a_q;
    assign bus.mult_b_o       = b_q;
    assign bus.resp_valid_o   = resp_valid_q;
    assign bus.resp_product_o = resp_product_q;
    assign bus.err_o          = err_q;

`ifdef MULT_ARB_PERF_EN
    logic        stall_c;
    logic [31:0] perf_issue_q;
    logic [31:0] perf_stall_q;

    assign stall_c = |(bus.req_valid_i & ~bus.req_ready_o);

    // Saturating event counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (xfer_c && (perf_issue_q != '1))  perf_issue_q <= perf_issue_q + 32'd1;
            if (stall_c && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issue_o = perf_issue_q;
    assign perf_stall_o = perf_stall_q;
`endif
endmodule

// File: tb/tb_mult_arb.sv
// Directed-vector bench for mult_arb with a reset-aware fixed-latency multiplier
// model and a scoreboard checking every response against a*b and its requester.
module tb_mult_arb;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned STAGES  = 16;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned BW      = $clog2(NUM_REQ * WIDTH);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic force_done = 1'b0;

    always #5 clk = ~clk;

    mult_arb_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

`ifdef MULT_ARB_PERF_EN
    logic [31:0] perf_issue, perf_stall;
`endif

    mult_arb #(.WIDTH(WIDTH), .STAGES(STAGES), .NUM_REQ(NUM_REQ)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
`ifdef MULT_ARB_PERF_EN
        ,
        .perf_issue_o (perf_issue),
        .perf_stall_o (perf_stall)
`endif
    );

    // Stand-in multiplier: done exactly STAGES cycles after the start cycle.
    logic [WIDTH:0] mpipe [STAGES];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) mpipe[i] <= '0;
        end else begin
            mpipe[0] <= {bus.mult_start_o, WIDTH'(bus.mult_a_o * bus.mult_b_o)};
            for (int i = 1; i < STAGES; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign bus.mult_done_i    = mpipe[STAGES-1][WIDTH] | force_done;
    assign bus.mult_product_i = mpipe[STAGES-1][WIDTH-1:0];

    int n_vec  = 0;
    int n_bad  = 0;
    int n_resp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int p);
        for (int i = 0; i < NUM_REQ; i++) begin
            int k = (p + i) % NUM_REQ;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // Scoreboard: grant model plus in-order expected responses.
    typedef struct packed {
        logic [1:0]       idx;
        logic [WIDTH-1:0] prod;
    } exp_t;
    exp_t sb[$];
    int   ptr_m = 0;
    int   m_idx;
    exp_t m_e;
    logic [WIDTH-1:0] m_a, m_b;
    logic [NUM_REQ-1:0] m_rdy;

    always @(negedge clk) begin
        #4;
        if (!rst_n) begin
            sb.delete();
            ptr_m = 0;
        end else begin
            m_idx = rr_pick(bus.req_valid_i, ptr_m);
            m_rdy = (m_idx < 0) ? '0 : NUM_REQ'(1 << m_idx);
            if ((bus.req_valid_i != '0) || (bus.req_ready_o != '0))
                check("grant", 32'(bus.req_ready_o), 32'(m_rdy));
            if (m_idx >= 0) begin
                m_a = bus.req_a_i[BW'(m_idx * WIDTH) +: WIDTH];
                m_b = bus.req_b_i[BW'(m_idx * WIDTH) +: WIDTH];
                sb.push_back('{idx: 2'(m_idx), prod: WIDTH'(m_a * m_b)});
                ptr_m = (m_idx + 1) % NUM_REQ;
            end
            if (bus.resp_valid_o != '0) begin
                n_resp++;
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'(bus.resp_valid_o), 32'd0);
                end else begin
                    m_e = sb.pop_front();
                    check("sb_route", 32'(bus.resp_valid_o), 32'(NUM_REQ'(1) << m_e.idx));
                    check("sb_product", bus.resp_product_o, m_e.prod);
                end
            end
        end
    end

    typedef struct {
        logic [NUM_REQ-1:0] valid;
        int                 win;
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [WIDTH-1:0]   prod;
    } vec_t;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        for (int n = 1; n <= int'(STAGES) + 8 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (bus.resp_valid_o != '0) lat = n;
        end
    endtask

    initial begin
        vec_t tbl [10];
        int   lat;
        int   base;
        int   issued;
        int   cyc;
        logic [NUM_REQ-1:0] exp_rdy;

        // Expected winners follow the pointer left by the previous row.
        tbl[0] = '{4'b0001, 0, 32'd2,          32'd3,          32'd6};
        tbl[1] = '{4'b0010, 1, 32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFFD};
        tbl[2] = '{4'b0101, 2, 32'hFFFF_FFEC,  32'd5,          32'hFFFF_FF9C};
        tbl[3] = '{4'b0011, 0, 32'h0001_0000,  32'h0001_0000,  32'h0};
        tbl[4] = '{4'b1001, 3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h1};
        tbl[5] = '{4'b1111, 0, 32'd7,          32'd9,          32'd63};
        tbl[6] = '{4'b1110, 1, 32'h8000_0000,  32'd2,          32'h0};
        tbl[7] = '{4'b0010, 1, 32'h1234_5678,  32'h10,         32'h2345_6780};
        tbl[8] = '{4'b1000, 3, 32'hDEAD_BEEF,  32'd1,          32'hDEAD_BEEF};
        tbl[9] = '{4'b0000, -1, 32'd5,         32'd5,          32'd0};

        bus.req_valid_i = '0;
        bus.req_a_i     = '0;
        bus.req_b_i     = '0;

        // Outputs held at reset values even with requests pending.
        repeat (3) @(negedge clk);
        bus.req_valid_i = '1;
        #1;
        check("rst_ready", 32'(bus.req_ready_o), 32'd0);
        check("rst_start", 32'(bus.mult_start_o), 32'd0);
        check("rst_mult_a", bus.mult_a_o, 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
        check("rst_resp_product", bus.resp_product_o, 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        @(negedge clk);
        bus.req_valid_i = '0;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.req_valid_i = tbl[i].valid;
            for (int k = 0; k < NUM_REQ; k++) begin
                bus.req_a_i[BW'(k * WIDTH) +: WIDTH] = (k == tbl[i].win) ? tbl[i].a : tbl[i].a + 32'(k + 1) * 32'h0101_0101;
                bus.req_b_i[BW'(k * WIDTH) +: WIDTH] = (k == tbl[i].win) ? tbl[i].b : tbl[i].b + 32'(k + 3);
            end
            exp_rdy = (tbl[i].win < 0) ? '0 : NUM_REQ'(1 << tbl[i].win);
            #1;
            check($sformatf("v%0d_ready", i), 32'(bus.req_ready_o), 32'(exp_rdy));
            @(posedge clk); #1;
            bus.req_valid_i = '0;
            check($sformatf("v%0d_start", i), 32'(bus.mult_start_o), (tbl[i].win >= 0) ? 32'd1 : 32'd0);
            if (tbl[i].win >= 0) begin
                check($sformatf("v%0d_mult_a", i), bus.mult_a_o, tbl[i].a);
                check($sformatf("v%0d_mult_b", i), bus.mult_b_o, tbl[i].b);
                // Transfer edge is t; the response is in cycle t+STAGES+2,
                // which opens STAGES+1 rising edges later.
                wait_resp(lat);
                check($sformatf("v%0d_latency", i), 32'(lat + 1), 32'(STAGES + 2));
                check($sformatf("v%0d_resp_valid", i), 32'(bus.resp_valid_o), 32'(exp_rdy));
                check($sformatf("v%0d_resp_product", i), bus.resp_product_o, tbl[i].prod);
                @(posedge clk); #1;
                check($sformatf("v%0d_resp_pulse", i), 32'(bus.resp_valid_o), 32'd0);
                check($sformatf("v%0d_err", i), 32'(bus.err_o), 32'd0);
            end else begin
                @(posedge clk); #1;
                check($sformatf("v%0d_idle_start", i), 32'(bus.mult_start_o), 32'd0);
                repeat (STAGES + 3) @(posedge clk);
            end
        end

        // Round-robin with all requesters held valid for 8 cycles.
        do_reset();
        base = n_resp;
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.req_a_i[BW'(k * WIDTH) +: WIDTH] = 32'(k + 10);
            bus.req_b_i[BW'(k * WIDTH) +: WIDTH] = 32'(k + 1);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus.req_valid_i = 4'b1111;
            #1;
            check($sformatf("rr%0d_ready", c), 32'(bus.req_ready_o), 32'(4'b0001 << (c % 4)));
            @(posedge clk); #1;
            check($sformatf("rr%0d_start", c), 32'(bus.mult_start_o), 32'd1);
            check($sformatf("rr%0d_mult_a", c), bus.mult_a_o, 32'((c % 4) + 10));
        end
        @(negedge clk);
        bus.req_valid_i = '0;
        repeat (STAGES + 6) @(negedge clk);
        check("rr_resp_count", 32'(n_resp - base), 32'd8);

        // Back-to-back issue from requesters 1 and 2, returned on consecutive cycles.
        bus.req_a_i[BW'(1 * WIDTH) +: WIDTH] = 32'hFFFF_FFFF;
        bus.req_b_i[BW'(1 * WIDTH) +: WIDTH] = 32'd3;
        bus.req_a_i[BW'(2 * WIDTH) +: WIDTH] = 32'hFFFF_FFEC;
        bus.req_b_i[BW'(2 * WIDTH) +: WIDTH] = 32'd5;
        bus.req_valid_i = 4'b0010;
        @(negedge clk);
        bus.req_valid_i = 4'b0100;
        @(posedge clk); #1;
        bus.req_valid_i = '0;
        wait_resp(lat);
        check("pipe_first_valid", 32'(bus.resp_valid_o), 32'h2);
        check("pipe_first_product", bus.resp_product_o, 32'hFFFF_FFFD);
        @(posedge clk); #1;
        check("pipe_second_valid", 32'(bus.resp_valid_o), 32'h4);
        check("pipe_second_product", bus.resp_product_o, 32'hFFFF_FF9C);
        repeat (4) @(negedge clk);

        // Reset two cycles after the last of three issues discards them all.
        base = n_resp;
        bus.req_valid_i = 4'b0111;
        repeat (3) @(posedge clk);
        #1;
        bus.req_valid_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (STAGES + 6) @(negedge clk);
        check("flush_resp_count", 32'(n_resp - base), 32'd0);
        check("flush_err", 32'(bus.err_o), 32'd0);

        // Done with an empty tag pipeline sets a sticky error, no response.
        @(negedge clk);
        force_done = 1'b1;
        @(posedge clk); #1;
        check("mismatch_err", 32'(bus.err_o), 32'd1);
        @(negedge clk);
        force_done = 1'b0;
        #1;
        check("mismatch_no_resp", 32'(bus.resp_valid_o), 32'd0);
        repeat (5) @(negedge clk);
        check("mismatch_sticky", 32'(bus.err_o), 32'd1);
        do_reset();
        #1;
        check("mismatch_cleared", 32'(bus.err_o), 32'd0);

        // Random traffic: every response checked by the scoreboard.
        base   = n_resp;
        issued = 0;
        cyc    = 0;
        while (issued < 1000 && cyc < 5000) begin
            @(negedge clk);
            bus.req_valid_i = NUM_REQ'($urandom_range(0, 15));
            for (int k = 0; k < NUM_REQ; k++) begin
                bus.req_a_i[BW'(k * WIDTH) +: WIDTH] = $urandom;
                bus.req_b_i[BW'(k * WIDTH) +: WIDTH] = $urandom;
            end
            #1;
            if ((bus.req_valid_i & bus.req_ready_o) != '0) issued++;
            cyc++;
        end
        @(negedge clk);
        bus.req_valid_i = '0;
        repeat (STAGES + 6) @(negedge clk);
        check("rand_issued", 32'(issued), 32'd1000);
        check("rand_resp_count", 32'(n_resp - base), 32'd1000);
        check("rand_drained", 32'(sb.size()), 32'd0);
        check("rand_err", 32'(bus.err_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
